noc_packetizer: RTL and testbench

NOC_PACKETIZER -- requirements
Module: noc_packetizer

---
 rtl/noc_pkg.sv | 22 ++
 rtl/noc_flit_reg.sv | 32 +++
 rtl/noc_packetizer.sv | 144 ++++++++++++++
 tb/tb_noc_packetizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit encoding, head-field bit positions and packetizer FSM state type.
package noc_pkg;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  localparam int unsigned HEAD_DEST_LSB = 60;
  localparam int unsigned HEAD_SRC_LSB  = 58;
  localparam int unsigned HEAD_LEN_LSB  = 54;
  localparam int unsigned HEAD_SEQ_LSB  = 46;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned SEQ_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/noc_flit_reg.sv
// One-entry valid/ready output register; loads whenever empty or being drained.
module noc_flit_reg #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         load_en_c
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign load_en_c   = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_en_c) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Turns a request plus payload beats into HEAD/BODY/TAIL flits for the local router port.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned INDEX         = 0,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned TYPE_WIDTH    = 2,
  parameter int unsigned FlitPerPacket = 16,
  localparam int unsigned DEST_W       = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned PL_W         = DATA_WIDTH - TYPE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DEST_W-1:0]     req_dest,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [PL_W-1:0]       pl_data,
  input  logic                  pl_valid,
  output logic                  pl_ready,
  output logic [DATA_WIDTH-1:0] flit_data,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  busy,
  output logic                  err_len
);

  localparam int unsigned MAX_LEN = FlitPerPacket - 2;

  state_e                  state_q, state_d;
  logic [DEST_W-1:0]       dest_q, dest_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic                    err_q, err_d;
  logic                    req_ready_q;
  logic                    load_en;
  logic                    fr_valid;
  logic [DATA_WIDTH-1:0]   fr_data;
  logic [DATA_WIDTH-1:0]   head_flit;
  logic [DEST_W-1:0]       hdr_dest;
  logic [LEN_W-1:0]        hdr_len;
  logic                    len_bad;

  assign req_ready = req_ready_q;
  assign err_len   = err_q;
  assign pl_ready  = (state_q == ST_PAYLOAD) && load_en;
  assign busy      = (state_q != ST_IDLE) || flit_valid;
  assign len_bad   = 32'(req_len) > MAX_LEN;

  // In IDLE the head is built straight from the request so it leaves one cycle after handshake.
  assign hdr_dest = (state_q == ST_IDLE) ? req_dest : dest_q;
  assign hdr_len  = (state_q == ST_IDLE) ? req_len  : len_q;

  always_comb begin
    head_flit = '0;
    head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]  = TYPE_WIDTH'(FLIT_HEAD);
    head_flit[HEAD_DEST_LSB +: DEST_W]     = hdr_dest;
    head_flit[HEAD_SRC_LSB +: DEST_W]      = DEST_W'(INDEX);
    head_flit[HEAD_LEN_LSB +: LEN_W]       = hdr_len;
    head_flit[HEAD_SEQ_LSB +: SEQ_W]       = seq_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      err_q       <= err_d;
      req_ready_q <= (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    err_d    = err_q;
    fr_valid = 1'b0;
    fr_data  = head_flit;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            dest_d = req_dest;
            len_d  = req_len;
            cnt_d  = req_len;
            // Head goes out immediately when the output register can take it.
            if (load_en) begin
              fr_valid = 1'b1;
              seq_d    = seq_q + SEQ_W'(1);
              state_d  = ST_PAYLOAD;
            end else begin
              state_d  = ST_HEAD;
            end
          end
        end
      end
      ST_HEAD: begin
        if (load_en) begin
          fr_valid = 1'b1;
          seq_d    = seq_q + SEQ_W'(1);
          state_d  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (pl_valid && load_en) begin
          fr_valid = 1'b1;
          fr_data  = {TYPE_WIDTH'((cnt_q == '0) ? FLIT_TAIL : FLIT_BODY), pl_data};
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  noc_flit_reg #(.W(DATA_WIDTH)) u_flit_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (fr_valid),
    .in_data_i   (fr_data),
    .out_ready_i (flit_ready),
    .out_valid_o (flit_valid),
    .out_data_o  (flit_data),
    .load_en_c   (load_en)
  );

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed checks of noc_packetizer flit framing, back-pressure, length error, seq wrap and reset.
module tb_noc_packetizer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dest;
  logic [3:0]  req_len;
  logic [61:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [63:0] flit_data;
  logic        flit_valid;
  logic        flit_ready;
  logic        busy;
  logic        err_len;

  int vectors    = 0;
  int miscompares = 0;

  logic [61:0] da, db, dc, dd, de, df;

  noc_packetizer #(
    .N(4), .INDEX(0), .DATA_WIDTH(64), .TYPE_WIDTH(2), .FlitPerPacket(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .pl_data    (pl_data),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .flit_data  (flit_data),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .busy       (busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] head_f(input int dest, input int len, input int seq);
    return {2'b01, 2'(dest), 2'b00, 4'(len), 8'(seq), 46'd0};
  endfunction

  function automatic logic [63:0] body_f(input logic [61:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [63:0] tail_f(input logic [61:0] d);
    return {2'b11, d};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    da = 62'h0000_0000_0000_00A1;
    db = 62'h0000_0000_0000_00B2;
    dc = 62'h2AAA_5555_AAAA_55C3;
    dd = 62'h1234_5678_9ABC_DEF0;
    de = 62'h0FED_CBA9_8765_4321;
    df = 62'h0000_0000_0000_00F6;

    rst = 1'b0; req_valid = 1'b0; req_dest = 2'd0; req_len = 4'd0;
    pl_data = '0; pl_valid = 1'b0; flit_ready = 1'b1;

    // Reset state
    #1;
    chk1 ("rst_flit_valid", flit_valid, 1'b0);
    chk64("rst_flit_data",  flit_data,  64'd0);
    chk1 ("rst_req_ready",  req_ready,  1'b0);
    chk1 ("rst_pl_ready",   pl_ready,   1'b0);
    chk1 ("rst_busy",       busy,       1'b0);
    chk1 ("rst_err_len",    err_len,    1'b0);
    tick(); tick();
    chk1 ("rst_req_ready_held", req_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk1 ("req_ready_before_edge", req_ready, 1'b0);
    tick();
    chk1 ("req_ready_first_edge", req_ready, 1'b1);

    // Basic 3-beat packet, no back-pressure
    req_valid = 1'b1; req_dest = 2'd2; req_len = 4'd2;
    tick();
    req_valid = 1'b0;
    chk1 ("a_head_valid", flit_valid, 1'b1);
    chk64("a_head",       flit_data,  head_f(2, 2, 0));
    chk1 ("a_req_ready",  req_ready,  1'b0);
    chk1 ("a_pl_ready",   pl_ready,   1'b1);
    pl_valid = 1'b1; pl_data = da;
    tick();
    chk64("a_body_a", flit_data, body_f(da));
    pl_data = db;
    tick();
    chk64("a_body_b", flit_data, body_f(db));
    pl_data = dc;
    tick();
    chk64("a_tail_c",  flit_data, tail_f(dc));
    chk1 ("a_tail_vld", flit_valid, 1'b1);
    chk1 ("a_busy_tail", busy, 1'b1);
    chk1 ("a_pl_ready_idle", pl_ready, 1'b0);
    chk1 ("a_req_ready_idle", req_ready, 1'b1);
    pl_valid = 1'b0;
    tick();
    chk1 ("a_drained_valid", flit_valid, 1'b0);
    chk1 ("a_drained_busy",  busy, 1'b0);

    // Head stalled for 5 cycles
    flit_ready = 1'b0;
    req_valid = 1'b1; req_dest = 2'd1; req_len = 4'd1;
    tick();
    req_valid = 1'b0;
    pl_valid = 1'b1; pl_data = dd;
    for (int i = 0; i < 5; i++) begin
      chk1 ("b_stall_valid",    flit_valid, 1'b1);
      chk64("b_stall_head",     flit_data,  head_f(1, 1, 1));
      chk1 ("b_stall_pl_ready", pl_ready,   1'b0);
      tick();
    end
    flit_ready = 1'b1;
    #1;
    chk1 ("b_release_pl_ready", pl_ready, 1'b1);
    tick();
    chk64("b_body_d", flit_data, body_f(dd));
    pl_data = de;
    tick();
    chk64("b_tail_e", flit_data, tail_f(de));
    pl_valid = 1'b0;
    tick();
    chk1 ("b_drained", flit_valid, 1'b0);

    // Single-payload packets, second one addressed to self
    req_valid = 1'b1; req_dest = 2'd3; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk64("c_head", flit_data, head_f(3, 0, 2));
    pl_valid = 1'b1; pl_data = df;
    tick();
    chk64("c_tail", flit_data, tail_f(df));
    pl_valid = 1'b0;
    req_valid = 1'b1; req_dest = 2'd0; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk64("c_self_head", flit_data, head_f(0, 0, 3));
    pl_valid = 1'b1; pl_data = da;
    tick();
    chk64("c_self_tail", flit_data, tail_f(da));
    pl_valid = 1'b0;
    tick();

    // Illegal length
    req_valid = 1'b1; req_dest = 2'd1; req_len = 4'hF;
    tick();
    req_valid = 1'b0;
    chk1 ("d_err_len",   err_len,    1'b1);
    chk1 ("d_no_flit",   flit_valid, 1'b0);
    chk1 ("d_req_ready", req_ready,  1'b1);
    tick();
    chk1 ("d_err_sticky", err_len,    1'b1);
    chk1 ("d_no_flit2",   flit_valid, 1'b0);
    chk1 ("d_busy",       busy,       1'b0);

    // 256 back-to-back packets; seq runs 4..255, 0..3
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b1; req_dest = 2'd1; req_len = 4'd0; pl_valid = 1'b0;
      tick();
      chk64("e_head", flit_data, head_f(1, 0, (4 + i) % 256));
      req_valid = 1'b0; pl_valid = 1'b1; pl_data = 62'(i);
      tick();
      chk64("e_tail", flit_data, tail_f(62'(i)));
    end
    pl_valid = 1'b0;
    tick();

    // Reset in the middle of a 6-beat packet
    req_valid = 1'b1; req_dest = 2'd2; req_len = 4'd5;
    tick();
    req_valid = 1'b0;
    chk64("f_head", flit_data, head_f(2, 5, 4));
    pl_valid = 1'b1; pl_data = da;
    tick();
    chk64("f_body1", flit_data, body_f(da));
    pl_data = db;
    tick();
    chk64("f_body2", flit_data, body_f(db));
    rst = 1'b0;
    #1;
    chk1 ("f_rst_valid",     flit_valid, 1'b0);
    chk64("f_rst_data",      flit_data,  64'd0);
    chk1 ("f_rst_req_ready", req_ready,  1'b0);
    chk1 ("f_rst_pl_ready",  pl_ready,   1'b0);
    chk1 ("f_rst_err_len",   err_len,    1'b0);
    pl_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1 ("f_req_ready", req_ready,  1'b1);
    chk1 ("f_no_tail",   flit_valid, 1'b0);
    req_valid = 1'b1; req_dest = 2'd3; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    chk64("f_new_head", flit_data, head_f(3, 0, 0));
    pl_valid = 1'b1; pl_data = dc;
    tick();
    chk64("f_new_tail", flit_data, tail_f(dc));
    pl_valid = 1'b0;
    tick();
    chk1 ("f_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
